// File: rtl/psg_bus_pkg.sv
// Shared types for the PSG BDIR/BC bus master: bus modes, FSM states and the
// per-register read masks of a YM2149-style register file.
package psg_bus_pkg;

    // Encoded directly as {BDIR,BC}
    typedef enum logic [1:0] {
        BUS_INACTIVE = 2'b00,
        BUS_READ     = 2'b01,
        BUS_WRITE    = 2'b10,
        BUS_LATCH    = 2'b11
    } bus_mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_WR,
        S_RD,
        S_GAP2
    } state_e;

    localparam logic [3:0] SHADOW_LAST = 4'd13;

    // Index 15 first: R15 .. R0
    localparam logic [15:0][7:0] RD_MASK = {
        8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h1F, 8'h1F, 8'h1F,
        8'hFF, 8'h1F, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF
    };

    function automatic logic [7:0] rd_mask(input logic [3:0] a);
        return RD_MASK[a];
    endfunction

endpackage

// File: rtl/psg_shadow_regs.sv
// Shadow copy of PSG registers R0..R13; full-width write port, combinational
// read that applies the chip's per-register bit masks.
module psg_shadow_regs
    import psg_bus_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_we,
    input  logic [3:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [3:0] i_raddr,
    output logic [7:0] o_rdata
);

    logic [13:0][7:0] r_regs;
    logic [7:0]       w_rdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_regs    <= '0;
            r_regs[7] <= 8'hFF;   // mixer: all channels/IO disabled
        end else begin
            for (int i = 0; i < 14; i++) begin
                if (i_we && i_waddr == 4'(i)) r_regs[i] <= i_wdata;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < 14; i++) begin
            if (i_raddr == 4'(i)) w_rdata = r_regs[i] & rd_mask(i_raddr);
        end
    end

    assign o_rdata = w_rdata;

endmodule

// File: rtl/psg_bus_master.sv
// Host-side BDIR/BC bus initiator for a YM2149-style PSG with a latched-address
// cache. Optional register shadow (reads of R0..R13 skip the bus): PSG_SHADOW_EN.
module psg_bus_master
    import psg_bus_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       BDIR,
    output logic       BC,
    output logic [7:0] DO,
    input  logic [7:0] DI
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 1) begin : g_hold_chk
        $error("HOLD_CYCLES must be >= 1");
    end

    state_e    r_state;
    bus_mode_e r_mode;
    logic [7:0]    r_do;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_addr;
    logic [7:0]    r_data;
    logic          r_write;
    logic          r_cache_vld;
    logic [3:0]    r_cache_addr;
    logic          r_ready;
    logic          r_rsp_valid;
    logic [7:0]    r_rsp_data;

    logic       w_accept;
    logic       w_hit;
    logic       w_shadow_rd;
    logic [7:0] w_shadow_rdata;

    assign w_accept = req_valid & r_ready;
    assign w_hit    = r_cache_vld & (r_cache_addr == req_addr);

`ifdef PSG_SHADOW_EN
    psg_shadow_regs u_shadow (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_we    (w_accept & req_write),
        .i_waddr (req_addr),
        .i_wdata (req_data),
        .i_raddr (req_addr),
        .o_rdata (w_shadow_rdata)
    );
    assign w_shadow_rd = ~req_write & (req_addr <= SHADOW_LAST);
`else
    assign w_shadow_rd    = 1'b0;
    assign w_shadow_rdata = 8'h00;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_mode       <= BUS_INACTIVE;
            r_do         <= '0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_write      <= 1'b0;
            r_cache_vld  <= 1'b0;
            r_cache_addr <= '0;
            r_ready      <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_addr  <= req_addr;
                    r_data  <= req_data;
                    r_write <= req_write;
                    r_cnt   <= CNT_LOAD;
                    if (w_shadow_rd) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_shadow_rdata;
                    end else if (w_hit) begin
                        r_ready <= 1'b0;
                        r_state <= req_write ? S_WR : S_RD;
                        r_mode  <= req_write ? BUS_WRITE : BUS_READ;
                        r_do    <= req_write ? req_data : 8'h00;
                    end else begin
                        r_ready <= 1'b0;
                        r_state <= S_ADDR;
                        r_mode  <= BUS_LATCH;
                        r_do    <= {4'h0, req_addr};
                    end
                end
                S_ADDR: begin
                    if (r_cnt == '0) begin
                        r_state      <= S_GAP1;
                        r_mode       <= BUS_INACTIVE;
                        r_do         <= '0;
                        r_cache_vld  <= 1'b1;
                        r_cache_addr <= r_addr;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP1: begin
                    r_state <= r_write ? S_WR : S_RD;
                    r_mode  <= r_write ? BUS_WRITE : BUS_READ;
                    r_do    <= r_write ? r_data : 8'h00;
                    r_cnt   <= CNT_LOAD;
                end
                S_WR, S_RD: begin
                    if (r_cnt == '0) begin
                        r_state <= S_GAP2;
                        r_mode  <= BUS_INACTIVE;
                        r_do    <= '0;
                        // DI is captured on the edge that closes the read phase
                        if (r_state == S_RD) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= DI;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP2: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_mode  <= BUS_INACTIVE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign {BDIR, BC} = r_mode;
    assign DO         = r_do;
    assign req_ready  = r_ready;
    assign busy       = ~r_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;

endmodule
